// File: rtl/seg7_pkg.sv
// Shared constants for the seven-segment scan driver: active-low glyph table,
// all-off pattern and the pin polarity helper.
package seg7_pkg;

   localparam logic [6:0] SEG_OFF = 7'b111_1111;

   // Index n holds the active-low {g,f,e,d,c,b,a} pattern for hex digit n.
   localparam logic [15:0][6:0] GLYPHS = {
      7'b0001110,
      7'b0000110,
      7'b0100001,
      7'b1000110,
      7'b0000011,
      7'b0001000,
      7'b0010000,
      7'b0000000,
      7'b1111000,
      7'b0000010,
      7'b0010010,
      7'b0011001,
      7'b0110000,
      7'b0100100,
      7'b1111001,
      7'b1000000
   };

   function automatic logic [6:0] apply_seg_pol(input logic [6:0] seg_al, input logic act_low);
      return act_low ? seg_al : ~seg_al;
   endfunction

endpackage

// File: rtl/seg7_hex_decode.sv
// Combinational hex nibble to active-low seven-segment glyph lookup.
module seg7_hex_decode
   import seg7_pkg::*;
(
   input  logic [3:0] nibble_i,
   output logic [6:0] seg_al_o
);

   assign seg_al_o = GLYPHS[nibble_i];

endmodule

// File: rtl/seg7_scan_driver.sv
// Time-multiplexed N-digit seven-segment driver with per-slot blanking,
// frame-synchronous display update and optional leading-zero blanking.
module seg7_scan_driver
   import seg7_pkg::*;
#(
   parameter int NUM_DIGITS   = 4,
   parameter int REFRESH_DIV  = 50000,
   parameter int BLANK_CYCLES = 16,
   parameter bit LZ_BLANK     = 1'b0,
   parameter bit SEG_ACT_LOW  = 1'b1,
   parameter bit AN_ACT_LOW   = 1'b1
)(
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic                    load,
   input  logic [4*NUM_DIGITS-1:0] value,
   input  logic [NUM_DIGITS-1:0]   dp_in,
   input  logic [NUM_DIGITS-1:0]   digit_en,
   output logic [6:0]              seg,
   output logic                    seg_dp,
   output logic [NUM_DIGITS-1:0]   an,
   output logic                    frame_done
);

   localparam int CNT_W = $clog2(REFRESH_DIV);
   localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
   localparam logic [CNT_W-1:0]      CNT_LAST    = CNT_W'(REFRESH_DIV - 1);
   localparam logic [IDX_W-1:0]      IDX_LAST    = IDX_W'(NUM_DIGITS - 1);
   localparam logic [6:0]            SEG_OFF_PIN = apply_seg_pol(SEG_OFF, SEG_ACT_LOW);
   localparam logic                  DP_OFF_PIN  = SEG_ACT_LOW;
   localparam logic [NUM_DIGITS-1:0] AN_OFF_PIN  = {NUM_DIGITS{AN_ACT_LOW}};

   logic [CNT_W-1:0]        div_cnt_q, div_cnt_d;
   logic [IDX_W-1:0]        idx_q, idx_d;
   logic [4*NUM_DIGITS-1:0] pend_val_q, pend_val_d, disp_val_q, disp_val_d;
   logic [NUM_DIGITS-1:0]   pend_dp_q, pend_dp_d, disp_dp_q, disp_dp_d;
   logic [NUM_DIGITS-1:0]   pend_en_q, pend_en_d, disp_en_q, disp_en_d;
   logic                    pend_valid_q, pend_valid_d;
   logic [6:0]              seg_q, seg_d;
   logic                    seg_dp_q, seg_dp_d;
   logic [NUM_DIGITS-1:0]   an_q, an_d;
   logic                    frame_done_q, frame_done_d;

   logic                    wrap, last_digit, boundary;
   logic                    higher_zero, in_blank, dig_off;
   logic                    dig_en, dig_dp, dig_lz;
   logic [3:0]              nib;
   logic [6:0]              glyph_al;
   logic [NUM_DIGITS-1:0]   an_lit;

   // Scan counters and pending/display transfer; display only changes at a frame boundary.
   always_comb begin
      wrap         = (div_cnt_q == CNT_LAST);
      last_digit   = (idx_q == IDX_LAST);
      boundary     = wrap && last_digit;
      div_cnt_d    = wrap ? '0 : div_cnt_q + 1'b1;
      idx_d        = idx_q;
      pend_val_d   = pend_val_q;
      pend_dp_d    = pend_dp_q;
      pend_en_d    = pend_en_q;
      pend_valid_d = pend_valid_q;
      disp_val_d   = disp_val_q;
      disp_dp_d    = disp_dp_q;
      disp_en_d    = disp_en_q;
      frame_done_d = 1'b0;
      if (wrap) begin
         idx_d = last_digit ? '0 : idx_q + 1'b1;
      end
      if (boundary && (load || pend_valid_q)) begin
         disp_val_d   = load ? value    : pend_val_q;
         disp_dp_d    = load ? dp_in    : pend_dp_q;
         disp_en_d    = load ? digit_en : pend_en_q;
         pend_valid_d = 1'b0;
         frame_done_d = 1'b1;
      end else if (load) begin
         pend_val_d   = value;
         pend_dp_d    = dp_in;
         pend_en_d    = digit_en;
         pend_valid_d = 1'b1;
      end
   end

   // Descending walk so higher_zero covers nibble i and everything above it.
   always_comb begin
      higher_zero = 1'b1;
      nib         = 4'h0;
      dig_en      = 1'b0;
      dig_dp      = 1'b0;
      dig_lz      = 1'b0;
      an_lit      = '0;
      for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
         higher_zero = higher_zero && (disp_val_q[4*i +: 4] == 4'h0);
         if (idx_q == IDX_W'(i)) begin
            nib       = disp_val_q[4*i +: 4];
            dig_en    = disp_en_q[i];
            dig_dp    = disp_dp_q[i];
            dig_lz    = LZ_BLANK && (i != 0) && higher_zero;
            an_lit[i] = 1'b1;
         end
      end
   end

   seg7_hex_decode u_dec (
      .nibble_i (nib),
      .seg_al_o (glyph_al)
   );

   always_comb begin
      in_blank = (int'(div_cnt_q) < BLANK_CYCLES);
      dig_off  = in_blank || !dig_en || dig_lz;
      seg_d    = dig_off ? SEG_OFF_PIN : apply_seg_pol(glyph_al, SEG_ACT_LOW);
      seg_dp_d = (dig_off || !dig_dp) ? DP_OFF_PIN : ~DP_OFF_PIN;
      an_d     = in_blank ? AN_OFF_PIN : (AN_ACT_LOW ? ~an_lit : an_lit);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         div_cnt_q    <= '0;
         idx_q        <= '0;
         pend_val_q   <= '0;
         pend_dp_q    <= '0;
         pend_en_q    <= '0;
         pend_valid_q <= 1'b0;
         disp_val_q   <= '0;
         disp_dp_q    <= '0;
         disp_en_q    <= '0;
         seg_q        <= SEG_OFF_PIN;
         seg_dp_q     <= DP_OFF_PIN;
         an_q         <= AN_OFF_PIN;
         frame_done_q <= 1'b0;
      end else begin
         div_cnt_q    <= div_cnt_d;
         idx_q        <= idx_d;
         pend_val_q   <= pend_val_d;
         pend_dp_q    <= pend_dp_d;
         pend_en_q    <= pend_en_d;
         pend_valid_q <= pend_valid_d;
         disp_val_q   <= disp_val_d;
         disp_dp_q    <= disp_dp_d;
         disp_en_q    <= disp_en_d;
         seg_q        <= seg_d;
         seg_dp_q     <= seg_dp_d;
         an_q         <= an_d;
         frame_done_q <= frame_done_d;
      end
   end

   assign seg        = seg_q;
   assign seg_dp     = seg_dp_q;
   assign an         = an_q;
   assign frame_done = frame_done_q;

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Directed bench for seg7_scan_driver: 4 digits, 8 clocks per slot, 2 blank
// cycles, active-low pins; a second instance has leading-zero blanking enabled.
module tb_seg7_scan_driver;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        load;
   logic [15:0] value;
   logic [3:0]  dp_in;
   logic [3:0]  digit_en;
   logic [6:0]  seg, seg_lz;
   logic        seg_dp, seg_dp_lz;
   logic [3:0]  an, an_lz;
   logic        fd, fd_lz;

   int n_cmp  = 0;
   int n_bad  = 0;
   int t      = 0;
   int fd_cnt = 0;

   typedef struct {
      logic [15:0] value;
      logic [3:0]  dp;
      logic [3:0]  en;
      logic [27:0] seg;
      logic [3:0]  dpo;
      logic [27:0] seg_lz;
   } vec_t;

   vec_t vecs[6];

   always #5 clk = ~clk;

   seg7_scan_driver #(
      .NUM_DIGITS(4), .REFRESH_DIV(8), .BLANK_CYCLES(2),
      .LZ_BLANK(1'b0), .SEG_ACT_LOW(1'b1), .AN_ACT_LOW(1'b1)
   ) dut (
      .clk(clk), .rst_n(rst_n), .load(load), .value(value), .dp_in(dp_in),
      .digit_en(digit_en), .seg(seg), .seg_dp(seg_dp), .an(an), .frame_done(fd)
   );

   seg7_scan_driver #(
      .NUM_DIGITS(4), .REFRESH_DIV(8), .BLANK_CYCLES(2),
      .LZ_BLANK(1'b1), .SEG_ACT_LOW(1'b1), .AN_ACT_LOW(1'b1)
   ) dut_lz (
      .clk(clk), .rst_n(rst_n), .load(load), .value(value), .dp_in(dp_in),
      .digit_en(digit_en), .seg(seg_lz), .seg_dp(seg_dp_lz), .an(an_lz), .frame_done(fd_lz)
   );

   always @(negedge clk) if (fd === 1'b1) fd_cnt++;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h, expected %h (t=%0d)", name, act, exp, t);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
      t++;
   endtask

   task automatic run_to(input int n);
      while (t < n) step();
   endtask

   function automatic int next_bnd();
      return (t / 32 + 1) * 32;
   endfunction

   task automatic load_at(input int e, input logic [15:0] v, input logic [3:0] dp, input logic [3:0] en);
      run_to(e - 1);
      value    = v;
      dp_in    = dp;
      digit_en = en;
      load     = 1'b1;
      step();
      load     = 1'b0;
   endtask

   task automatic check_slot(input string tag, input int d, input int dv,
                             input logic [6:0] es, input logic edp, input logic [6:0] esl);
      logic [3:0] ea;
      ea = ~(4'b0001 << d);
      if (dv < 2) begin
         check({tag, " an off"}, an, 4'hF);
         check({tag, " seg off"}, seg, 7'h7F);
         check({tag, " dp off"}, seg_dp, 1'b1);
         check({tag, " lz an off"}, an_lz, 4'hF);
         check({tag, " lz seg off"}, seg_lz, 7'h7F);
      end else begin
         check({tag, " an"}, an, ea);
         check({tag, " seg"}, seg, es);
         check({tag, " dp"}, seg_dp, edp);
         check({tag, " lz an"}, an_lz, ea);
         check({tag, " lz seg"}, seg_lz, esl);
         check({tag, " lz dp"}, seg_dp_lz, edp);
      end
   endtask

   task automatic apply_vec(input int i);
      int nb, fd0;
      int dvs[4];
      dvs = '{0, 1, 2, 7};
      nb = next_bnd();
      if (nb - 10 <= t) nb += 32;
      load_at(nb - 10, vecs[i].value, vecs[i].dp, vecs[i].en);
      fd0 = fd_cnt;
      run_to(nb);
      check($sformatf("v%0d frame_done pulse", i), fd, 1'b1);
      check($sformatf("v%0d lz frame_done pulse", i), fd_lz, 1'b1);
      run_to(nb + 1);
      check($sformatf("v%0d frame_done drop", i), fd, 1'b0);
      for (int d = 0; d < 4; d++) begin
         for (int k = 0; k < 4; k++) begin
            run_to(nb + 8 * d + dvs[k] + 1);
            check_slot($sformatf("v%0d d%0d c%0d", i, d, dvs[k]), d, dvs[k],
                       vecs[i].seg[7*d +: 7], vecs[i].dpo[d], vecs[i].seg_lz[7*d +: 7]);
         end
      end
      check($sformatf("v%0d frame_done count", i), fd_cnt - fd0, 1);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int nb, fd0;

      vecs[0] = '{16'h12AF, 4'h0, 4'hF,
                  {7'b1111001, 7'b0100100, 7'b0001000, 7'b0001110}, 4'hF,
                  {7'b1111001, 7'b0100100, 7'b0001000, 7'b0001110}};
      vecs[1] = '{16'h0040, 4'h0, 4'hF,
                  {7'b1000000, 7'b1000000, 7'b0011001, 7'b1000000}, 4'hF,
                  {7'b1111111, 7'b1111111, 7'b0011001, 7'b1000000}};
      vecs[2] = '{16'h0000, 4'h0, 4'hF,
                  {7'b1000000, 7'b1000000, 7'b1000000, 7'b1000000}, 4'hF,
                  {7'b1111111, 7'b1111111, 7'b1111111, 7'b1000000}};
      vecs[3] = '{16'h9E5C, 4'b0101, 4'b1011,
                  {7'b0010000, 7'b1111111, 7'b0010010, 7'b1000110}, 4'b1110,
                  {7'b0010000, 7'b1111111, 7'b0010010, 7'b1000110}};
      vecs[4] = '{16'h3478, 4'hF, 4'hF,
                  {7'b0110000, 7'b0011001, 7'b1111000, 7'b0000000}, 4'h0,
                  {7'b0110000, 7'b0011001, 7'b1111000, 7'b0000000}};
      vecs[5] = '{16'h0B6D, 4'h0, 4'hF,
                  {7'b1000000, 7'b0000011, 7'b0000010, 7'b0100001}, 4'hF,
                  {7'b1111111, 7'b0000011, 7'b0000010, 7'b0100001}};

      rst_n = 1'b0; load = 1'b0; value = '0; dp_in = '0; digit_en = '0;
      repeat (3) @(posedge clk);
      #2;
      check("reset an", an, 4'hF);
      check("reset seg", seg, 7'h7F);
      check("reset dp", seg_dp, 1'b1);
      check("reset frame_done", fd, 1'b0);
      check("reset lz an", an_lz, 4'hF);
      @(negedge clk) rst_n = 1'b1;
      t = 0;

      // Idle after reset: nothing loaded, digit 0 slot scans but stays blank.
      run_to(2);
      check_slot("idle", 0, 1, 7'h7F, 1'b1, 7'h7F);
      run_to(3);
      check_slot("idle", 0, 2, 7'h7F, 1'b1, 7'h7F);
      run_to(70);
      check("idle frame_done count", fd_cnt, 0);

      for (int i = 0; i < 6; i++) apply_vec(i);

      // Two loads in one frame: last one wins, single commit; no tearing meanwhile.
      nb = next_bnd();
      if (nb - 20 <= t) nb += 32;
      fd0 = fd_cnt;
      load_at(nb - 20, 16'h1111, 4'h0, 4'hF);
      load_at(nb - 10, 16'h2222, 4'h0, 4'hF);
      run_to(nb - 5);
      check_slot("dbl pre", 3, 2, 7'b1000000, 1'b1, 7'h7F);
      run_to(nb + 3);
      check_slot("dbl", 0, 2, 7'b0100100, 1'b1, 7'b0100100);
      run_to(nb + 11);
      check_slot("dbl", 1, 2, 7'b0100100, 1'b1, 7'b0100100);
      run_to(nb + 40);
      check("dbl frame_done count", fd_cnt - fd0, 1);

      // Load on the boundary cycle itself commits straight through.
      nb = next_bnd();
      fd0 = fd_cnt;
      load_at(nb, 16'h5555, 4'h0, 4'hF);
      check("bnd frame_done pulse", fd, 1'b1);
      run_to(nb + 3);
      check_slot("bnd", 0, 2, 7'b0010010, 1'b1, 7'b0010010);
      run_to(nb + 33);
      check("bnd frame_done count", fd_cnt - fd0, 1);

      // Mid-frame load must not disturb the remaining slots of the current frame.
      nb = next_bnd();
      load_at(nb - 10, 16'h3333, 4'h0, 4'hF);
      run_to(nb + 3);
      check_slot("mid", 0, 2, 7'b0110000, 1'b1, 7'b0110000);
      load_at(nb + 12, 16'h8888, 4'h0, 4'hF);
      run_to(nb + 19);
      check_slot("mid", 2, 2, 7'b0110000, 1'b1, 7'b0110000);
      run_to(nb + 32);
      check_slot("mid", 3, 7, 7'b0110000, 1'b1, 7'b0110000);
      check("mid frame_done pulse", fd, 1'b1);
      run_to(nb + 35);
      check_slot("mid next", 0, 2, 7'b0000000, 1'b1, 7'b0000000);

      // Reset mid-slot with data pending: outputs drop at once, pending is lost.
      nb = next_bnd();
      load_at(nb + 5, 16'h7777, 4'h0, 4'hF);
      run_to(nb + 6);
      check("rst pre seg", seg, 7'b0000000);
      #2;
      rst_n = 1'b0;
      #1;
      check("rst async an", an, 4'hF);
      check("rst async seg", seg, 7'h7F);
      check("rst async dp", seg_dp, 1'b1);
      check("rst async lz seg", seg_lz, 7'h7F);
      repeat (2) @(posedge clk);
      @(negedge clk) rst_n = 1'b1;
      t = 0;
      fd0 = fd_cnt;
      run_to(3);
      check_slot("rst post", 0, 2, 7'h7F, 1'b1, 7'h7F);
      run_to(40);
      check("rst frame_done count", fd_cnt - fd0, 0);
      check_slot("rst post frame", 0, 7, 7'h7F, 1'b1, 7'h7F);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
